nibble_parity_sequencer: RTL

Sequential parity engine that reuses a single 4-input XOR stage across a wider data word. The block latches a word of NIBBLES×4 bits. It then steps the 4-input XOR across the word one nibble per clock and accumulates the result into a parity bit. Finally it compares that bit against an expected value. It sits between a word source (switch bank or upstream register) and the lab status LEDs. It replaces a wide XOR tree with one shared 4-input XOR scheduled over time.

---
 rtl/nibble_parity_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/nibble_parity_sequencer.sv
// nibble_parity_sequencer
// Computes the parity of a NIBBLES*4-bit word with a single shared 4-input XOR
// that visits one nibble per clock, LSB nibble first. The result is then
// compared against a captured expected parity bit.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; din/exp_par are captured on the accepting edge
// SCAN  | folding one nibble per edge into acc; nib_idx tracks the nibble
// DONE  | one-cycle done pulse; parity/err are valid
module nibble_parity_sequencer #(
  parameter int NIBBLES = 4,
  parameter bit ODD     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] din,
  input  logic                 exp_par,
  output logic                 busy,
  output logic                 done,
  output logic                 parity,
  output logic                 err,
  output logic [2:0]           nib_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  state_t               state;
  state_t               state_nx;
  logic [4*NIBBLES-1:0] sr;
  logic                 acc;
  logic                 exp_q;
  logic                 fold;
  logic                 last_nib;

  // The one shared 4-input XOR, applied to whichever nibble sits at the bottom of sr
  assign fold     = sr[3] ^ sr[2] ^ sr[1] ^ sr[0];
  assign last_nib = (nib_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (last_nib) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SCAN:    busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: capture, nibble-serial accumulate, and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      acc     <= 1'b0;
      exp_q   <= 1'b0;
      nib_idx <= 3'd0;
      parity  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= din;
            exp_q   <= exp_par;
            acc     <= ODD;
            nib_idx <= 3'd0;
          end
        end
        SCAN: begin
          acc <= acc ^ fold;
          sr  <= sr >> 4;
          if (last_nib) begin
            // The final nibble is folded straight into the result registers
            parity  <= acc ^ fold;
            err     <= acc ^ fold ^ exp_q;
            nib_idx <= 3'd0;
          end else begin
            nib_idx <= nib_idx + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
